// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage HI/LO unit: funct codes, FSM encoding, widths.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative magnitude datapath: radix-2 shift-add multiply or restoring divide,
// one bit per step. Results are unsigned magnitudes; sign fix-up is done by the caller.
module ex_muldiv_iter
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              is_div,
  input  logic              step,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  // hi_q:lo_q is the 64-bit working register. Multiply: hi = partial product,
  // lo = multiplier shifting out. Divide: hi = remainder, lo = dividend/quotient.
  logic [DATA_W-1:0] hi_q, lo_q, m_q;
  logic              div_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W:0]   sum, shifted, trial;
  logic [DATA_W-1:0] nxt_hi, nxt_lo;

  // One iteration of either algorithm, selected by the latched op kind.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shifted = {hi_q, lo_q[DATA_W-1]};
    trial   = shifted - {1'b0, m_q};
    nxt_hi  = sum[DATA_W:1];
    nxt_lo  = {sum[0], lo_q[DATA_W-1:1]};
    if (div_q) begin
      // Remainder stays below the divisor, so trial[DATA_W] is a clean borrow flag.
      nxt_hi = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
      nxt_lo = {lo_q[DATA_W-2:0], ~trial[DATA_W]};
    end
  end

  assign done = step && (cnt_q == CNT_W'(DATA_W - 1));
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Operand load on start, then one iteration per step with the counter advancing.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      hi_q  <= '0;
      lo_q  <= is_div ? op_a : op_b;
      m_q   <= is_div ? op_b : op_a;
      div_q <= is_div;
      cnt_q <= '0;
    end else if (step) begin
      hi_q  <= nxt_hi;
      lo_q  <= nxt_lo;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO unit: funct decode, sign handling, HI/LO registers and stall.
// Handshake: an op is taken at a rising edge where it is valid and o_Busy is low;
// while o_Busy is high any HI/LO op is held by o_EX_Stall until the unit frees up.
module ex_muldiv
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_EX_valid,
  input  logic [5:0]        i_EX_data_Funct,
  input  logic [DATA_W-1:0] i_EX_data_RSData,
  input  logic [DATA_W-1:0] i_EX_data_RTData,
  output logic [DATA_W-1:0] o_EX_Result,
  output logic              o_EX_Stall,
  output logic              o_Busy,
  output logic [DATA_W-1:0] o_HI,
  output logic [DATA_W-1:0] o_LO
);

  state_t            state_q, state_d;
  logic              busy_q;
  logic [DATA_W-1:0] hi_q, lo_q, rs_q;
  logic              div_q, neg_q, rem_neg_q, dz_q;

  logic              hilo_op, is_md, is_div_op, is_signed_op, accept, dz;
  logic [DATA_W-1:0] mag_a, mag_b, it_hi, it_lo;
  logic              it_done;
  logic [2*DATA_W-1:0] prod;

  // Decode of the funct field and operand magnitudes for the iterative unit.
  always_comb begin
    is_md        = i_EX_data_Funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    hilo_op      = i_EX_valid && (is_md ||
                   (i_EX_data_Funct inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO}));
    is_div_op    = (i_EX_data_Funct == FN_DIV) || (i_EX_data_Funct == FN_DIVU);
    is_signed_op = (i_EX_data_Funct == FN_MULT) || (i_EX_data_Funct == FN_DIV);
    accept       = hilo_op && !busy_q && is_md;
    dz           = is_div_op && (i_EX_data_RTData == '0);
    mag_a        = (is_signed_op && i_EX_data_RSData[DATA_W-1]) ? -i_EX_data_RSData
                                                                 : i_EX_data_RSData;
    mag_b        = (is_signed_op && i_EX_data_RTData[DATA_W-1]) ? -i_EX_data_RTData
                                                                 : i_EX_data_RTData;
  end

  ex_muldiv_iter u_iter (
    .clk    (clk),
    .nrst   (nrst),
    .start  (accept && !dz),
    .is_div (is_div_op),
    .step   (state_q == ST_RUN),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .done   (it_done),
    .hi     (it_hi),
    .lo     (it_lo)
  );

  // Next-state logic: divide-by-zero skips the iterations and goes straight to FIX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = dz ? ST_FIX : ST_RUN;
      ST_RUN:  if (it_done) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, busy flag and the per-op sign/kind bookkeeping captured at accept.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      rs_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        busy_q    <= 1'b1;
        div_q     <= is_div_op;
        neg_q     <= is_signed_op &&
                     (i_EX_data_RSData[DATA_W-1] ^ i_EX_data_RTData[DATA_W-1]);
        rem_neg_q <= is_signed_op && i_EX_data_RSData[DATA_W-1];
        dz_q      <= dz;
        rs_q      <= i_EX_data_RSData;
      end else if (state_q == ST_FIX) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign prod = {it_hi, it_lo};

  // HI/LO architectural registers: written at FIX or by MTHI/MTLO when idle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == ST_FIX) begin
      if (dz_q) begin
        lo_q <= '1;
        hi_q <= rs_q;
      end else if (div_q) begin
        lo_q <= neg_q ? -it_lo : it_lo;
        hi_q <= rem_neg_q ? -it_hi : it_hi;
      end else begin
        {hi_q, lo_q} <= neg_q ? -prod : prod;
      end
    end else if (hilo_op && !busy_q) begin
      if (i_EX_data_Funct == FN_MTHI) hi_q <= i_EX_data_RSData;
      if (i_EX_data_Funct == FN_MTLO) lo_q <= i_EX_data_RSData;
    end
  end

  // Move-from result mux and stall generation.
  always_comb begin
    o_EX_Result = '0;
    if (hilo_op && i_EX_data_Funct == FN_MFHI) o_EX_Result = hi_q;
    if (hilo_op && i_EX_data_Funct == FN_MFLO) o_EX_Result = lo_q;
  end

  assign o_EX_Stall = busy_q && hilo_op;
  assign o_Busy     = busy_q;
  assign o_HI       = hi_q;
  assign o_LO       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: completions (busy length + HI/LO) and move-from
// results are queued when issued and checked by an independent monitor.
module tb_ex_muldiv;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        valid = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] rs_d = '0, rt_d = '0;
  logic [31:0] result, hi, lo;
  logic        stall, busy;

  int checks = 0;
  int errors = 0;

  // {busy length[71:64], HI[63:32], LO[31:0]} per completed or aborted operation
  logic [71:0] exp_q[$];
  logic [31:0] res_q[$];

  localparam logic [5:0] FN_ADD = 6'h20;

  ex_muldiv dut (
    .clk              (clk),
    .nrst             (nrst),
    .i_EX_valid       (valid),
    .i_EX_data_Funct  (funct),
    .i_EX_data_RSData (rs_d),
    .i_EX_data_RTData (rt_d),
    .o_EX_Result      (result),
    .o_EX_Stall       (stall),
    .o_Busy           (busy),
    .o_HI             (hi),
    .o_LO             (lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge
  task automatic drive(input logic v, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid = v; funct = fn; rs_d = a; rt_d = b;
  endtask

  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, fn, a, b);
  endtask

  task automatic bubble();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic wait_idle();
    int n = 0;
    #2;
    while (busy && n < 100) begin
      @(negedge clk); #2; n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, n);
    end
  endtask

  // Holds the current instruction until stall drops; returns the stalled cycle count.
  task automatic hold_until_no_stall(output int n);
    n = 0;
    #2;
    while (stall && n < 100) begin
      n++;
      @(negedge clk); #2;
    end
  endtask

  // scoreboard monitor
  initial begin : monitor
    int run_len = 0;
    logic [71:0] e;
    logic [31:0] r;
    forever begin
      @(negedge clk); #1;
      if (busy) begin
        run_len++;
      end else if (run_len != 0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_completion: len %0d hi %h lo %h, expected none", run_len, hi, lo);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (run_len[7:0] !== e[71:64] || hi !== e[63:32] || lo !== e[31:0]) begin
            errors++;
            $display("FAIL completion: len %0d hi %h lo %h, expected len %0d hi %h lo %h",
                     run_len, hi, lo, e[71:64], e[63:32], e[31:0]);
          end
        end
        run_len = 0;
      end
      if (valid && (funct == FN_MFHI || funct == FN_MFLO) && !stall) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mf: result %h, expected none", result);
        end else begin
          r = res_q.pop_front();
          checks++;
          if (result !== r) begin
            errors++;
            $display("FAIL mf_result: got %h, expected %h", result, r);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_hi_lo", {hi, lo}, 64'h0);
    check("reset_state", 64'(dut.state_q), 64'(ST_IDLE));
    @(negedge clk); nrst = 1'b1;
    #1;
    check("reset_stall_result", {31'h0, stall, result}, 64'h0);

    // MULTU max x max
    exp_q.push_back({8'd33, 32'hFFFFFFFE, 32'h00000001});
    issue(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF); bubble(); wait_idle();

    // MULT -3 x 7
    exp_q.push_back({8'd33, 32'hFFFFFFFF, 32'hFFFFFFEB});
    issue(FN_MULT, 32'hFFFFFFFD, 32'h00000007); bubble(); wait_idle();

    // DIV -7 / 2
    exp_q.push_back({8'd33, 32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(FN_DIV, 32'hFFFFFFF9, 32'h00000002); bubble(); wait_idle();

    // DIVU by zero
    exp_q.push_back({8'd1, 32'h00000007, 32'hFFFFFFFF});
    issue(FN_DIVU, 32'h00000007, 32'h0); bubble(); wait_idle();

    // signed overflow
    exp_q.push_back({8'd33, 32'h00000000, 32'h80000000});
    issue(FN_DIV, 32'h80000000, 32'hFFFFFFFF); bubble(); wait_idle();

    // DIVU 100 / 7
    exp_q.push_back({8'd33, 32'h00000002, 32'h0000000E});
    issue(FN_DIVU, 32'd100, 32'd7); bubble(); wait_idle();

    // MULT 5x6 then MFLO immediately
    exp_q.push_back({8'd33, 32'h0, 32'h0000001E});
    res_q.push_back(32'h0000001E);
    issue(FN_MULT, 32'd5, 32'd6);
    issue(FN_MFLO, 32'h0, 32'h0);
    hold_until_no_stall(n);
    check("mflo_stall_cycles", 64'(n), 64'd33);
    bubble();

    // MULT 2x3 with ADD instructions during busy
    exp_q.push_back({8'd33, 32'h0, 32'h00000006});
    issue(FN_MULT, 32'd2, 32'd3);
    for (int i = 0; i < 4; i++) begin
      issue(FN_ADD, 32'h11111111 * i, 32'h1);
      #2;
      check("add_no_stall", {63'h0, stall}, 64'h0);
    end
    bubble(); wait_idle();

    // MTHI then MFHI, no stall
    res_q.push_back(32'h12345678);
    issue(FN_MTHI, 32'h12345678, 32'h0);
    issue(FN_MFHI, 32'h0, 32'h0);
    hold_until_no_stall(n);
    check("mfhi_no_stall", 64'(n), 64'd0);
    // bubble carrying MTLO must not write
    drive(1'b0, FN_MTLO, 32'hDEADBEEF, 32'h0);
    bubble(); #2;
    check("bubble_mtlo_lo", {32'h0, lo}, 64'h00000006);
    // real MTLO then MFLO
    res_q.push_back(32'hAABBCCDD);
    issue(FN_MTLO, 32'hAABBCCDD, 32'h0);
    issue(FN_MFLO, 32'h0, 32'h0);
    hold_until_no_stall(n);
    bubble();

    // reset during a DIVU at iteration 10
    exp_q.push_back({8'd11, 32'h0, 32'h0});
    issue(FN_DIVU, 32'hFFFF0000, 32'd3); bubble();
    repeat (10) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk); nrst = 1'b1;
    #2;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_hi_lo", {hi, lo}, 64'h0);
    check("abort_state", 64'(dut.state_q), 64'(ST_IDLE));

    // MULTU 3x4 after abort
    exp_q.push_back({8'd33, 32'h0, 32'h0000000C});
    issue(FN_MULTU, 32'd3, 32'd4); bubble(); wait_idle();

    repeat (3) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("res_q_drained", 64'(res_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
